// File: rtl/pwm_capture.sv
// pwm_capture: measures an external PWM waveform.
//   After each complete period it reports the period and the high time in clk cycles,
//   and the duty quantised to DUTY_W bits: floor(high * 2^DUTY_W / period).
//
// Ports
//   clk         in   1       system clock, all logic on posedge
//   rst         in   1       asynchronous, active-high reset
//   pwm_in      in   1       asynchronous PWM input
//   duty_cycle  out  DUTY_W  quantised duty of the last complete period
//   high_time   out  CNT_W   high cycles of the last complete period
//   period      out  CNT_W   cycles between the last two rising edges
//   valid       out  1       1-cycle pulse when the three results update
//   overrun     out  1       1-cycle pulse: period completed while divider busy, dropped
//   timeout     out  1       level: no rising edge for 2^CNT_W-1 cycles
//
// state | meaning
// ARM   | waiting for the first rise (after reset or timeout); that rise only reloads
// MEAS  | counting a period; the next rise snapshots period/high and starts the divide
// DIV   | restoring divide, one quotient bit per cycle; results register on the last
module pwm_capture #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic [CNT_W-1:0]  high_time,
  output logic [CNT_W-1:0]  period,
  output logic              valid,
  output logic              overrun,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int DC_W = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DUTY_W - 1);

  typedef enum logic [1:0] {ARM, MEAS, DIV} state_t;
  state_t state, state_nxt;

  logic sync1, sync2, prev;
  logic rise, sat;
  logic [CNT_W-1:0] per_cnt, hi_cnt, per_snap, hi_snap;
  logic [CNT_W:0] rem, rem_sh, rem_nxt, per_ext;
  logic [DUTY_W-1:0] quo, quo_nxt;
  logic [DC_W-1:0] div_cnt;
  logic q_bit;
  logic do_snap, do_done, do_to, do_ovr;

  assign rise = sync2 & ~prev;
  // A rise in the same cycle as saturation is a legitimate full-length period.
  assign sat  = (per_cnt == CNT_MAX) & ~rise;

  // Remainder stays below the divisor, so the shifted value fits in CNT_W+1 bits.
  assign per_ext = {1'b0, per_snap};
  assign rem_sh  = rem << 1;
  assign q_bit   = (rem_sh >= per_ext);
  assign rem_nxt = q_bit ? (rem_sh - per_ext) : rem_sh;
  assign quo_nxt = (quo << 1) | DUTY_W'(q_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Counters saturate at CNT_MAX; the high counter freezes with the period counter
  // so it can never wrap past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else if (per_cnt != CNT_MAX) begin
      per_cnt <= per_cnt + CNT_W'(1);
      hi_cnt  <= hi_cnt + CNT_W'(sync2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_snap   = 1'b0;
    do_done   = 1'b0;
    do_to     = 1'b0;
    do_ovr    = 1'b0;
    case (state)
      ARM: begin
        if (rise) state_nxt = MEAS;
        else if (sat && !timeout) do_to = 1'b1;
      end
      MEAS: begin
        if (rise) begin
          do_snap   = 1'b1;
          state_nxt = DIV;
        end else if (sat) begin
          do_to     = 1'b1;
          state_nxt = ARM;
        end
      end
      DIV: begin
        // The running divide always completes; a pending timeout is seen from MEAS.
        do_ovr = rise;
        if (div_cnt == DC_LAST) begin
          do_done   = 1'b1;
          state_nxt = MEAS;
        end
      end
      default: state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_snap <= '0;
      hi_snap  <= '0;
      rem      <= '0;
      quo      <= '0;
      div_cnt  <= '0;
    end else if (do_snap) begin
      per_snap <= per_cnt;
      hi_snap  <= hi_cnt;
      rem      <= {1'b0, hi_cnt};
      quo      <= '0;
      div_cnt  <= '0;
    end else if (state == DIV) begin
      rem      <= rem_nxt;
      quo      <= quo_nxt;
      div_cnt  <= div_cnt + DC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_cycle <= '0;
      high_time  <= '0;
      period     <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid   <= do_done;
      overrun <= do_ovr;
      if (rise)       timeout <= 1'b0;
      else if (do_to) timeout <= 1'b1;
      if (do_done) begin
        duty_cycle <= quo_nxt;
        high_time  <= hi_snap;
        period     <= per_snap;
      end else if (do_to) begin
        duty_cycle <= sync2 ? '1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (CNT_W=8, DUTY_W=3). Each scenario is a per-cycle level list
// for pwm_in; a reference model derives the expected valid/overrun/timeout events
// from rise positions in that list and they are compared against a negedge monitor.
module tb_pwm_capture;

  localparam int CW   = 8;
  localparam int DW   = 3;
  localparam int MAXC = (1 << CW) - 1;
  localparam int DMAX = (1 << DW) - 1;

  logic clk, rst, pwm_in;
  logic [DW-1:0] duty_cycle;
  logic [CW-1:0] high_time, period;
  logic valid, overrun, timeout;

  pwm_capture #(.CNT_W(CW), .DUTY_W(DW)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty_cycle(duty_cycle), .high_time(high_time), .period(period),
    .valid(valid), .overrun(overrun), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int edge_n;
    int per;
    int hi;
    int duty;
  } vrec_t;

  int n_checks = 0;
  int n_errors = 0;
  int lv[$];
  vrec_t exp_v[$], got_v[$];
  int exp_ovr[$], got_ovr[$], exp_to[$], got_to[$];
  int exp_per, exp_hi, exp_duty, exp_tout;
  int cur_edge = 0;
  bit mon_en = 0;
  bit to_prev = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) got_v.push_back('{cur_edge, int'(period), int'(high_time), int'(duty_cycle)});
      if (overrun) got_ovr.push_back(cur_edge);
      if (timeout && !to_prev) got_to.push_back(cur_edge);
      to_prev = timeout;
    end
  end

  task automatic add_per(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int t = 0; t < p; t++) lv.push_back((t < h) ? 1 : 0);
  endtask

  task automatic add_lvl(input int v, input int n);
    for (int k = 0; k < n; k++) lv.push_back(v);
  endtask

  // Input level at edge t reaches the DUT's rise detector two edges later; a rise is
  // measured only if the divider has finished, i.e. more than DW edges after the
  // last measured rise. A gap longer than MAXC times out and the next rise only arms.
  task automatic build_model();
    int r[$];
    int last_acc, h, gap, last;
    exp_v.delete(); exp_ovr.delete(); exp_to.delete();
    exp_per = 0; exp_hi = 0; exp_duty = 0; exp_tout = 0;
    for (int t = 0; t < lv.size(); t++)
      if (lv[t] == 1 && (t == 0 || lv[t-1] == 0)) r.push_back(t);
    if (r.size() == 0) begin
      if (lv.size() > MAXC + 4) begin
        exp_to.push_back(-1);
        exp_tout = 1;
      end
      return;
    end
    last_acc = -1000;
    for (int k = 1; k < r.size(); k++) begin
      gap = r[k] - r[k-1];
      if (gap > MAXC) begin
        exp_to.push_back(r[k-1] + MAXC + 2);
        exp_duty = lv[r[k-1] + MAXC] ? DMAX : 0;
        last_acc = -1000;
      end else if (r[k] - last_acc > DW) begin
        h = 0;
        for (int t = r[k-1]; t < r[k]; t++) h += lv[t];
        exp_per  = gap;
        exp_hi   = h;
        exp_duty = (h << DW) / gap;
        exp_v.push_back('{r[k] + 2 + DW, gap, h, exp_duty});
        last_acc = r[k];
      end else begin
        exp_ovr.push_back(r[k] + 2);
      end
    end
    last = r[r.size()-1];
    if (lv.size() - last > MAXC + 4) begin
      exp_to.push_back(last + MAXC + 2);
      exp_duty = lv[last + MAXC] ? DMAX : 0;
      exp_tout = 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rst_duty"}, duty_cycle, 0);
    check({tag, ".rst_high"}, high_time, 0);
    check({tag, ".rst_period"}, period, 0);
    check({tag, ".rst_valid"}, valid, 0);
    check({tag, ".rst_overrun"}, overrun, 0);
    check({tag, ".rst_timeout"}, timeout, 0);
  endtask

  task automatic start_run(input string tag);
    rst = 1'b1;
    pwm_in = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_v.delete(); got_ovr.delete(); got_to.delete();
    to_prev = 0;
    mon_en = 1;
  endtask

  task automatic run_scen(input string tag);
    int n;
    add_lvl(0, 8);
    build_model();
    start_run(tag);
    for (int t = 0; t < lv.size(); t++) begin
      pwm_in = lv[t][0];
      @(posedge clk);
      cur_edge = t;
      #1;
    end
    mon_en = 0;
    check({tag, ".n_valid"}, got_v.size(), exp_v.size());
    n = (got_v.size() < exp_v.size()) ? got_v.size() : exp_v.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.v%0d.edge", tag, i), got_v[i].edge_n, exp_v[i].edge_n);
      check($sformatf("%s.v%0d.period", tag, i), got_v[i].per, exp_v[i].per);
      check($sformatf("%s.v%0d.high", tag, i), got_v[i].hi, exp_v[i].hi);
      check($sformatf("%s.v%0d.duty", tag, i), got_v[i].duty, exp_v[i].duty);
    end
    check({tag, ".n_overrun"}, got_ovr.size(), exp_ovr.size());
    n = (got_ovr.size() < exp_ovr.size()) ? got_ovr.size() : exp_ovr.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.ovr%0d.edge", tag, i), got_ovr[i], exp_ovr[i]);
    check({tag, ".n_timeout"}, got_to.size(), exp_to.size());
    n = (got_to.size() < exp_to.size()) ? got_to.size() : exp_to.size();
    for (int i = 0; i < n; i++)
      if (exp_to[i] >= 0) check($sformatf("%s.to%0d.edge", tag, i), got_to[i], exp_to[i]);
    check({tag, ".final_period"}, period, exp_per);
    check({tag, ".final_high"}, high_time, exp_hi);
    check({tag, ".final_duty"}, duty_cycle, exp_duty);
    check({tag, ".final_timeout"}, timeout, exp_tout);
    lv.delete();
  endtask

  // Rises at edges 0, 8, 16: the second produces a valid at edge 13, the third is
  // in its divide when reset hits just after edge 19.
  task automatic reset_mid_div();
    start_run("rst_div");
    for (int t = 0; t < 20; t++) begin
      pwm_in = ((t % 8) < 3) ? 1'b1 : 1'b0;
      @(posedge clk);
      cur_edge = t;
      #1;
    end
    mon_en = 0;
    check("rst_div.pre_n_valid", got_v.size(), 1);
    check("rst_div.pre_period", period, 8);
    check("rst_div.pre_duty", duty_cycle, 3);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_div.async");
    @(posedge clk);
    #1;
    check("rst_div.valid_after", valid, 0);
    check("rst_div.period_after", period, 0);
  endtask

  initial begin
    int p, h;
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    add_per(8, 3, 4);
    run_scen("p8h3");

    for (int hh = 1; hh < 8; hh++) begin
      add_per(8, hh, 3);
      run_scen($sformatf("sweep_h%0d", hh));
    end

    add_lvl(0, 270);
    run_scen("const_low");
    add_lvl(1, 270);
    run_scen("const_high");

    add_per(100, 50, 3);
    run_scen("p100h50");
    add_per(3, 1, 8);
    run_scen("p3h1");
    add_per(2, 1, 10);
    run_scen("p2h1");

    add_per(10, 4, 3);
    add_lvl(0, 300);
    add_per(10, 4, 3);
    run_scen("stuck_resume");

    lv.push_back(1); add_lvl(0, 254);
    lv.push_back(1); add_lvl(0, 255);
    lv.push_back(1); add_lvl(0, 10);
    run_scen("sat_boundary");

    reset_mid_div();
    add_per(8, 3, 3);
    run_scen("after_rst");

    for (int s = 0; s < 6; s++) begin
      add_lvl(0, $urandom_range(0, 5));
      for (int k = 0; k < 30; k++) begin
        p = $urandom_range(2, 20);
        h = $urandom_range(1, p - 1);
        add_lvl(1, h);
        add_lvl(0, p - h);
        if ($urandom_range(0, 19) == 0) add_lvl(0, $urandom_range(260, 300));
      end
      run_scen($sformatf("rand%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
